hazard_scheduler: RTL

- Sequences issue from ID into the 5-stage pipeline.
- Tracks in-flight register-file writes in a shift-register scoreboard and raises a stall on read-after-write hazards.
- Drives a flush sequence after a branch-taken or jump redirect, and counts stall cycles.
- Sits beside the ID stage and consumes its decoded op1/op2 addresses, write destination, write enable and load select.

---
 rtl/hazard_scheduler_if.sv | 29 ++
 rtl/hazard_scheduler.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler_if.sv
// ID-stage to hazard_scheduler bus: decoded operands in; stall, flush, forward selects and stall count out.
// master = ID stage side, slave = scheduler side.
interface hazard_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [2:0]       id_op1;
  logic [2:0]       id_op2;
  logic             id_uses_op2;
  logic             id_rf_we;
  logic [2:0]       id_dest;
  logic             id_is_load;
  logic             redirect;
  logic             stall_o;
  logic             flush_o;
  logic [1:0]       fwd1_sel_o;
  logic [1:0]       fwd2_sel_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output id_valid, id_op1, id_op2, id_uses_op2, id_rf_we, id_dest, id_is_load, redirect,
    input  stall_o, flush_o, fwd1_sel_o, fwd2_sel_o, stall_cnt_o
  );

  modport slave (
    input  id_valid, id_op1, id_op2, id_uses_op2, id_rf_we, id_dest, id_is_load, redirect,
    output stall_o, flush_o, fwd1_sel_o, fwd2_sel_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Issue sequencer for the 5-stage pipe: RAW scoreboard stall, redirect flush FSM, saturating stall counter.
// Optional macro HAZARD_SCHEDULER_FORWARD_EN: stall only on load-use and drive forward selects.
module hazard_scheduler #(
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scheduler_if.slave  bus
);

  localparam int unsigned REG_W  = 3;
  localparam int unsigned FCNT_W = 3;
`ifdef HAZARD_SCHEDULER_FORWARD_EN
  localparam int unsigned FWD_N  = (DEPTH < 3) ? DEPTH : 3;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [DEPTH-1:0]    sb_valid;
  logic [REG_W-1:0]    sb_dest [DEPTH];
`ifdef HAZARD_SCHEDULER_FORWARD_EN
  logic [DEPTH-1:0]    sb_load;
`endif
  logic [DEPTH-1:0]    match1, match2;
  logic                stall_c;
  logic                flush;
  logic                issue;
  logic [1:0]          fwd1_c, fwd2_c;
  logic [CNT_W-1:0]    cnt_q;

  assign flush = (state_q == FLUSH);
  assign issue = bus.id_valid & ~stall_c & ~flush;

  // Source-vs-in-flight compare; register 0 never matches.
  always_comb begin
    match1 = '0;
    match2 = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      match1[k] = (bus.id_op1 != '0) && sb_valid[k] && (sb_dest[k] == bus.id_op1);
      match2[k] = bus.id_uses_op2 && (bus.id_op2 != '0) && sb_valid[k] && (sb_dest[k] == bus.id_op2);
    end
  end

`ifdef HAZARD_SCHEDULER_FORWARD_EN
  // Only a load in EX cannot be forwarded; otherwise pick the youngest producer.
  always_comb begin
    stall_c = bus.id_valid & ~flush & sb_valid[0] & sb_load[0] & (match1[0] | match2[0]);
    fwd1_c  = 2'd0;
    fwd2_c  = 2'd0;
    if (bus.id_valid && !flush && !stall_c) begin
      for (int k = int'(FWD_N) - 1; k >= 0; k--) begin
        if (match1[k]) fwd1_c = 2'(k + 1);
        if (match2[k]) fwd2_c = 2'(k + 1);
      end
    end
  end
`else
  always_comb begin
    stall_c = bus.id_valid & ~flush & ((|match1) | (|match2));
    fwd1_c  = 2'd0;
    fwd2_c  = 2'd0;
  end
`endif

  assign bus.stall_o    = stall_c;
  assign bus.flush_o    = flush;
  assign bus.fwd1_sel_o = fwd1_c;
  assign bus.fwd2_sel_o = fwd2_c;
  assign bus.stall_cnt_o = cnt_q;

  // Scoreboard shift: EX entry takes the issuing instruction or a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_valid <= '0;
      for (int k = 0; k < int'(DEPTH); k++) sb_dest[k] <= '0;
`ifdef HAZARD_SCHEDULER_FORWARD_EN
      sb_load  <= '0;
`endif
    end else begin
      sb_valid[0] <= issue & bus.id_rf_we & (bus.id_dest != '0);
      sb_dest[0]  <= bus.id_dest;
`ifdef HAZARD_SCHEDULER_FORWARD_EN
      sb_load[0]  <= bus.id_is_load;
`endif
      for (int k = 1; k < int'(DEPTH); k++) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_dest[k]  <= sb_dest[k-1];
`ifdef HAZARD_SCHEDULER_FORWARD_EN
        sb_load[k]  <= sb_load[k-1];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // A redirect always (re)arms the full flush window.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          state_d = FLUSH;
          fcnt_d  = FCNT_W'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (bus.redirect) begin
          fcnt_d = FCNT_W'(FLUSH_CYCLES);
        end else if (fcnt_q == FCNT_W'(1)) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (stall_c && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
